// File: rtl/pio_shift_out.sv
// pio_shift_out: serialises pio_in into a 74HC595-style register whenever it changes.
// Optional periodic refresh frames when SHIFT_OUT_REFRESH_EN is defined.
module pio_shift_out #(
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_PERIOD = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  pio_in,
    output logic        sr_sclk,
    output logic        sr_data,
    output logic        sr_latch,
    output logic        busy,
    output logic [15:0] frame_count
);
    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    if (CLK_DIV < 1 || CLK_DIV > 255 || REFRESH_PERIOD < 1)
        $error("pio_shift_out: illegal parameter value");

    state_t      state, state_n;
    logic [7:0]  div_cnt, snapshot, last_sent;
    logic [2:0]  idx;
    logic        force_flag, pending, phase_done, refresh_hit;

    assign pending    = (pio_in != last_sent) || force_flag;
    assign phase_done = div_cnt == 8'(CLK_DIV - 1);

`ifdef SHIFT_OUT_REFRESH_EN
    localparam int RW = $clog2(REFRESH_PERIOD) + 1;
    logic [RW-1:0] ref_cnt;
    assign refresh_hit = state == IDLE && !pending && ref_cnt == RW'(REFRESH_PERIOD - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ref_cnt <= '0;
        else if (state != IDLE || refresh_hit) ref_cnt <= '0;
        else if (!pending) ref_cnt <= ref_cnt + RW'(1);
`else
    assign refresh_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = pending ? SHIFT_LO : IDLE;
            SHIFT_LO: state_n = phase_done ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: state_n = !phase_done ? SHIFT_HI : (idx == 3'd0 ? LATCH : SHIFT_LO);
            default:  state_n = phase_done ? IDLE : LATCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;

    // Outputs are registered copies of the next state, so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            snapshot    <= '0;
            last_sent   <= '0;
            idx         <= '0;
            force_flag  <= 1'b1;
            sr_sclk     <= 1'b0;
            sr_data     <= 1'b0;
            sr_latch    <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            div_cnt  <= (state == IDLE || state_n != state) ? 8'd0 : div_cnt + 8'd1;
            sr_sclk  <= state_n == SHIFT_HI;
            sr_latch <= state_n == LATCH;
            busy     <= state_n != IDLE;
            if (state == IDLE && pending) begin
                snapshot   <= pio_in;
                idx        <= 3'd7;
                sr_data    <= pio_in[7];
                force_flag <= 1'b0;
            end
            if (refresh_hit) force_flag <= 1'b1;
            if (state == SHIFT_HI && phase_done && idx != 3'd0) begin
                idx     <= idx - 3'd1;
                sr_data <= snapshot[idx - 3'd1];
            end
            if (state == LATCH && phase_done) begin
                last_sent   <= snapshot;
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pio_shift_out.sv
// tb_pio_shift_out: directed checks of pio_shift_out at CLK_DIV=2 and CLK_DIV=1.
module tb_pio_shift_out;
    logic        clk = 0, reset_n = 0, rst1_n = 0;
    logic [7:0]  pio_in = 8'h00, pio1 = 8'h00;
    logic        sr_sclk, sr_data, sr_latch, busy;
    logic        sclk1, data1, latch1, busy1;
    logic [15:0] frame_count, fc1;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    pio_shift_out #(.CLK_DIV(2), .REFRESH_PERIOD(100)) u_dut (
        .clk(clk), .reset_n(reset_n), .pio_in(pio_in), .sr_sclk(sr_sclk), .sr_data(sr_data),
        .sr_latch(sr_latch), .busy(busy), .frame_count(frame_count));

    pio_shift_out #(.CLK_DIV(1), .REFRESH_PERIOD(100)) u_dut1 (
        .clk(clk), .reset_n(rst1_n), .pio_in(pio1), .sr_sclk(sclk1), .sr_data(data1),
        .sr_latch(latch1), .busy(busy1), .frame_count(fc1));

    typedef struct {
        logic [7:0] b;
        int         rises;
        int         busy_len;
        int         latch_len;
    } frame_t;
    frame_t frames[$];

    int         cur_busy = 0, cur_rises = 0, cur_latch = 0, stab_err = 0;
    logic [7:0] shreg = 0;
    logic       p_sclk = 0, p_data = 0, p_busy = 0;

    // Frame monitor: collects shifted bits, busy and latch lengths per completed frame.
    always @(negedge clk) begin
        if (!reset_n) begin
            cur_busy = 0; cur_rises = 0; cur_latch = 0; shreg = 0;
        end else begin
            if (busy) cur_busy++;
            if (sr_sclk && !p_sclk) begin cur_rises++; shreg = {shreg[6:0], sr_data}; end
            if (sr_sclk && p_sclk && sr_data !== p_data) stab_err++;
            if (sr_latch) cur_latch++;
            if (!busy && p_busy) begin
                frames.push_back('{shreg, cur_rises, cur_busy, cur_latch});
                cur_busy = 0; cur_rises = 0; cur_latch = 0;
            end
        end
        p_sclk = sr_sclk; p_data = sr_data; p_busy = busy;
    end

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames.size() < n && k < budget) begin @(negedge clk); k++; end
        checks++;
        if (frames.size() < n) begin errors++; $display("FAIL wait_frames: got %0d frames, need %0d", frames.size(), n); end
    endtask

    task automatic check_frame(input string nm, input int i, input logic [7:0] b);
        checks++;
        if (frames.size() <= i) begin errors++; $display("FAIL %s missing: frames %0d, need index %0d", nm, frames.size(), i); return; end
        checks += 4;
        if (frames[i].b !== b) begin errors++; $display("FAIL %s byte: got %h, expected %h", nm, frames[i].b, b); end
        if (frames[i].rises != 8) begin errors++; $display("FAIL %s rises: got %0d, expected 8", nm, frames[i].rises); end
        if (frames[i].busy_len != 34) begin errors++; $display("FAIL %s busy_len: got %0d, expected 34", nm, frames[i].busy_len); end
        if (frames[i].latch_len != 2) begin errors++; $display("FAIL %s latch_len: got %0d, expected 2", nm, frames[i].latch_len); end
    endtask

    task automatic check_idle_outputs(input string nm, input logic [15:0] fc);
        checks++;
        if ({sr_sclk, sr_data, sr_latch, busy} !== 4'b0000 || frame_count !== fc) begin
            errors++;
            $display("FAIL %s: sclk/data/latch/busy=%b%b%b%b fc=%0d, expected 0000 fc=%0d",
                     nm, sr_sclk, sr_data, sr_latch, busy, frame_count, fc);
        end
    endtask

    task automatic test_reset;
        pio_in = 8'hA5;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 16'd0);
    endtask

    task automatic test_first_frame;
        reset_n = 1;
        wait_frames(1, 200);
        check_frame("first_A5", 0, 8'hA5);
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL first fc: got %0d, expected 1", frame_count); end
        repeat (50) @(negedge clk);
        checks++;
        if (frames.size() != 1 || busy !== 1'b0) begin errors++; $display("FAIL first_idle: frames %0d busy %b, expected 1 0", frames.size(), busy); end
    endtask

    task automatic test_change;
        pio_in = 8'h3C;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL change_start: busy %b, expected 1", busy); end
        wait_frames(2, 200);
        check_frame("change_3C", 1, 8'h3C);
        checks++;
        if (frame_count !== 16'd2) begin errors++; $display("FAIL change fc: got %0d, expected 2", frame_count); end
    endtask

    task automatic test_midframe;
        pio_in = 8'h01;
        repeat (10) @(negedge clk);
        pio_in = 8'h02;
        repeat (10) @(negedge clk);
        pio_in = 8'h03;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy %b, expected 1", busy); end
        wait_frames(4, 300);
        repeat (200) @(negedge clk);
        checks++;
        if (frames.size() != 4) begin errors++; $display("FAIL mid_count: frames %0d, expected 4", frames.size()); end
        check_frame("mid_01", 2, 8'h01);
        check_frame("mid_03", 3, 8'h03);
        checks++;
        if (frame_count !== 16'd4) begin errors++; $display("FAIL mid fc: got %0d, expected 4", frame_count); end
    endtask

    task automatic test_reset_mid;
        int   rises = 0, k = 0;
        logic ps = 0;
        int   base;
        pio_in = 8'h55;
        while (rises < 4 && k < 200) begin
            @(negedge clk);
            if (sr_sclk && !ps) rises++;
            ps = sr_sclk; k++;
        end
        checks++;
        if (rises != 4) begin errors++; $display("FAIL rst_mid_rise: rises %0d, expected 4", rises); end
        base = frames.size();
        reset_n = 0;
        #1;
        check_idle_outputs("rst_mid_async", 16'd0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        wait_frames(base + 1, 200);
        check_frame("rst_mid_55", base, 8'h55);
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL rst_mid fc: got %0d, expected 1", frame_count); end
    endtask

    task automatic test_no_refresh;
        int base = frames.size();
        repeat (10000) @(negedge clk);
        checks++;
        if (frames.size() != base || frame_count !== 16'd1) begin
            errors++; $display("FAIL no_refresh: frames %0d fc %0d, expected %0d 1", frames.size(), frame_count, base);
        end
    endtask

    task automatic test_clkdiv1;
        int   blen = 0, toggle_err = 0, data_err = 0, r = 0;
        logic ps = 0, first = 1;
        pio1 = 8'hFF;
        @(negedge clk);
        rst1_n = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy1) begin
                blen++;
                if (data1 !== 1'b1) data_err++;
                if (!first && sclk1 === ps) toggle_err++;
                if (sclk1 && !ps) r++;
                first = 0;
            end
            ps = sclk1;
        end
        checks += 4;
        if (blen != 17) begin errors++; $display("FAIL div1_busy: got %0d, expected 17", blen); end
        if (toggle_err != 0 || r != 8) begin errors++; $display("FAIL div1_sclk: toggle_err %0d rises %0d, expected 0 8", toggle_err, r); end
        if (data_err != 0) begin errors++; $display("FAIL div1_data: %0d non-1 samples, expected 0", data_err); end
        if (fc1 !== 16'd1) begin errors++; $display("FAIL div1_fc: got %0d, expected 1", fc1); end
    endtask

    task automatic test_stability;
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL data_stable: %0d changes during sclk high, expected 0", stab_err); end
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_change;
        test_midframe;
        test_reset_mid;
        test_no_refresh;
        test_clkdiv1;
        test_stability;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
